// File: rtl/motion_pkg.sv
// Shared motion-control types and constants for the stepper axis blocks.
package motion_pkg;

  // Move sequencer states; SETUP is only reachable when the direction setup
  // wait is compiled in (STEPPER_DIR_SETUP_EN).
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WAIT_TICK,
    PULSE,
    DONE
  } stepper_state_t;

  localparam int STEP_BITS_DEFAULT = 16;

endpackage

// File: rtl/stepper_pulse_gen_pulse_stretcher.sv
// pulse_stretcher: loadable down-counter that holds 'active' high for exactly
// PULSE_CYCLES clk cycles after 'start'. 'last' flags the final high cycle,
// 'kill' truncates the pulse on the next edge.
module pulse_stretcher #(
  parameter int PULSE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic kill,
  output logic active,
  output logic last
);

  localparam int CW = $clog2(PULSE_CYCLES + 1);

  logic [CW-1:0] cnt_reg;
  logic          active_reg;

  // Width counter: loaded on start, counts down to zero while the pulse runs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (kill) begin
      cnt_reg <= '0;
    end else if (start) begin
      cnt_reg <= CW'(PULSE_CYCLES);
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  // Registered pulse output so the STEP pin is driven straight from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_reg <= 1'b0;
    end else if (kill) begin
      active_reg <= 1'b0;
    end else if (start) begin
      active_reg <= 1'b1;
    end else if (last) begin
      active_reg <= 1'b0;
    end
  end

  assign active = active_reg;
  assign last   = active_reg && (cnt_reg == CW'(1));

endmodule

// File: rtl/stepper_pulse_gen.sv
// stepper_pulse_gen: turns rate ticks into STEP/DIR drive for one axis.
// Optional feature macro: STEPPER_DIR_SETUP_EN adds a SETUP state that waits
// DIR_SETUP_TICKS ticks after each accepted non-zero command before pulsing.
module stepper_pulse_gen
  import motion_pkg::*;
#(
  parameter int STEP_BITS       = STEP_BITS_DEFAULT,
  parameter int PULSE_CYCLES    = 4,
  parameter int DIR_SETUP_TICKS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [STEP_BITS-1:0] cmd_steps,
  input  logic                 cmd_dir,
  input  logic                 abort,
  output logic                 step,
  output logic                 dir,
  output logic                 busy,
  output logic                 done,
  output logic [STEP_BITS-1:0] steps_left
);

  stepper_state_t       state_reg, state_next;
  logic                 dir_reg, dir_next;
  logic [STEP_BITS-1:0] steps_left_reg, steps_left_next;
  logic                 pulse_start, pulse_kill, pulse_active, pulse_last;

`ifdef STEPPER_DIR_SETUP_EN
  localparam int SETUP_W = $clog2(DIR_SETUP_TICKS + 1);
  localparam stepper_state_t MOVE_ENTRY = SETUP;

  logic [SETUP_W-1:0] setup_cnt_reg;
  logic               setup_last;

  assign setup_last = (setup_cnt_reg == SETUP_W'(DIR_SETUP_TICKS - 1));

  // Counts setup ticks; cleared whenever the sequencer is outside SETUP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      setup_cnt_reg <= '0;
    end else if (state_reg != SETUP) begin
      setup_cnt_reg <= '0;
    end else if (tick && !abort) begin
      setup_cnt_reg <= setup_cnt_reg + 1'b1;
    end
  end
`else
  localparam stepper_state_t MOVE_ENTRY = WAIT_TICK;

  logic unused_dir_setup;
  assign unused_dir_setup = (DIR_SETUP_TICKS != 0);
`endif

  // State, direction and remaining-step registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      dir_reg        <= 1'b0;
      steps_left_reg <= '0;
    end else begin
      state_reg      <= state_next;
      dir_reg        <= dir_next;
      steps_left_reg <= steps_left_next;
    end
  end

  // Next-state logic; abort always beats a coincident tick.
  always_comb begin
    state_next      = state_reg;
    dir_next        = dir_reg;
    steps_left_next = steps_left_reg;
    pulse_start     = 1'b0;
    pulse_kill      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          dir_next        = cmd_dir;
          steps_left_next = cmd_steps;
          state_next      = (cmd_steps == '0) ? DONE : MOVE_ENTRY;
        end
      end
`ifdef STEPPER_DIR_SETUP_EN
      SETUP: begin
        if (abort) begin
          state_next = DONE;
        end else if (tick && setup_last) begin
          state_next = WAIT_TICK;
        end
      end
`endif
      WAIT_TICK: begin
        if (abort) begin
          state_next = DONE;
        end else if (tick) begin
          pulse_start = 1'b1;
          state_next  = PULSE;
        end
      end
      PULSE: begin
        if (abort) begin
          // A truncated pulse leaves steps_left untouched.
          pulse_kill = 1'b1;
          state_next = DONE;
        end else if (pulse_last) begin
          if (steps_left_reg != '0) begin
            steps_left_next = steps_left_reg - 1'b1;
          end
          state_next = (steps_left_reg <= STEP_BITS'(1)) ? DONE : WAIT_TICK;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  pulse_stretcher #(
    .PULSE_CYCLES(PULSE_CYCLES)
  ) u_stretch (
    .clk   (clk),
    .reset (reset),
    .start (pulse_start),
    .kill  (pulse_kill),
    .active(pulse_active),
    .last  (pulse_last)
  );

  assign step       = pulse_active;
  assign dir        = dir_reg;
  assign steps_left = steps_left_reg;
  assign cmd_ready  = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign done       = (state_reg == DONE);

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Bench for stepper_pulse_gen: directed moves plus randomized moves, every
// cycle compared against a move-level behavioural model.
module tb_stepper_pulse_gen;

  localparam int SB  = 16;
  localparam int PC  = 4;
  localparam int DST = 1;
`ifdef STEPPER_DIR_SETUP_EN
  localparam bit SETUP_EN = 1'b1;
`else
  localparam bit SETUP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [SB-1:0] cmd_steps;
  logic          cmd_dir;
  logic          abort;
  logic          step;
  logic          dir;
  logic          busy;
  logic          done;
  logic [SB-1:0] steps_left;

  int checks = 0;
  int errors = 0;

  // Behavioural model of one axis move.
  bit m_busy;
  bit m_done_now;
  bit m_dir;
  int m_left;
  int m_hi;
  int m_setup_rem;
  int m_pulses;

  int period = 0;
  int phase  = 0;
  int rises  = 0;
  int dones  = 0;
  logic step_prev = 1'b0;

  stepper_pulse_gen #(
    .STEP_BITS      (SB),
    .PULSE_CYCLES   (PC),
    .DIR_SETUP_TICKS(DST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_steps (cmd_steps),
    .cmd_dir   (cmd_dir),
    .abort     (abort),
    .step      (step),
    .dir       (dir),
    .busy      (busy),
    .done      (done),
    .steps_left(steps_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done_now = 0; m_dir = 0; m_left = 0;
    m_hi = 0; m_setup_rem = 0; m_pulses = 0;
  endtask

  // Apply the move rules for one clock edge using the sampled inputs.
  task automatic model_edge();
    if (m_done_now) begin
      m_done_now = 0;
      m_busy     = 0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        m_dir    = cmd_dir;
        m_left   = int'(cmd_steps);
        m_busy   = 1;
        m_pulses = 0;
        if (cmd_steps == 0) m_done_now = 1;
        else m_setup_rem = SETUP_EN ? DST : 0;
      end
    end else if (abort) begin
      m_hi       = 0;
      m_done_now = 1;
    end else if (m_hi > 0) begin
      m_hi--;
      if (m_hi == 0) begin
        m_left--;
        if (m_left == 0) m_done_now = 1;
      end
    end else if (tick) begin
      if (m_setup_rem > 0) begin
        m_setup_rem--;
      end else begin
        m_hi = PC;
        m_pulses++;
      end
    end
  endtask

  task automatic check_outputs();
    chk("step", step, m_hi > 0);
    chk("busy", busy, m_busy);
    chk("done", done, m_done_now);
    chk("cmd_ready", cmd_ready, !m_busy);
    chk("dir", dir, m_dir);
    chk("steps_left", steps_left, m_left);
  endtask

  // One clock: model the edge, check 1 time unit later, then set next tick.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    if (step && !step_prev) rises++;
    if (done) dones++;
    step_prev = step;
    tick = (period > 0) && (phase % period == 0);
    phase++;
  endtask

  task automatic run_move(input int steps, input bit d, input int per,
                          input int abort_pulse, input int abort_cycle);
    int n;
    period    = per;
    phase     = 1;
    rises     = 0;
    dones     = 0;
    cmd_valid = 1'b1;
    cmd_steps = SB'(steps);
    cmd_dir   = d;
    n = 0;
    while (!m_busy && n < 50) begin
      cycle();
      n++;
    end
    cmd_valid = 1'b0;
    cmd_steps = SB'($urandom);
    cmd_dir   = 1'($urandom);
    n = 0;
    while (m_busy && n < 3000) begin
      abort = 1'b0;
      if (abort_pulse != 0 && m_pulses == abort_pulse && m_hi == PC - 1) abort = 1'b1;
      if (abort_cycle != 0 && n == abort_cycle) abort = 1'b1;
      cycle();
      n++;
    end
    abort = 1'b0;
    chk("move_end_busy", busy, 0);
    chk("done_count", dones, 1);
    if (abort_pulse == 0 && abort_cycle == 0) begin
      chk("pulse_count", rises, steps);
      chk("final_left", steps_left, 0);
    end
    $display("move steps=%0d dir=%0d period=%0d pulses=%0d left=%0d cycles=%0d",
             steps, d, per, rises, steps_left, n);
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    tick      = 1'b0;
    cmd_valid = 1'b0;
    cmd_steps = '0;
    cmd_dir   = 1'b0;
    abort     = 1'b0;
    model_reset();
    #12;
    chk("rst_step", step, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_dir", dir, 0);
    chk("rst_left", steps_left, 0);
    @(negedge clk);
    reset = 1'b0;

    run_move(3, 1'b1, 10, 0, 0);   // basic move
    run_move(0, 1'b0, 10, 0, 0);   // zero-step command
    run_move(2, 1'b0, 10, 0, 0);   // direction setup path when compiled in
    run_move(5, 1'b1, 10, 2, 0);   // abort two cycles into the 2nd pulse
    chk("abort_left", steps_left, 4);
    run_move(4, 1'b0, 3, 0, 0);    // ticks faster than a pulse
    run_move(2, 1'b1, 1, 0, 0);    // tick held high

    for (int i = 0; i < 14; i++) begin
      int st, per, ac;
      st  = $urandom_range(0, 6);
      per = $urandom_range(2, 12);
      ac  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 0;
      run_move(st, 1'($urandom), per, 0, ac);
    end

    // Asynchronous reset in the middle of a pulse.
    period    = 10;
    phase     = 1;
    cmd_valid = 1'b1;
    cmd_steps = SB'(5);
    cmd_dir   = 1'b1;
    n = 0;
    while (!m_busy && n < 50) begin
      cycle();
      n++;
    end
    cmd_valid = 1'b0;
    n = 0;
    while (m_hi != PC - 1 && n < 200) begin
      cycle();
      n++;
    end
    chk("pre_reset_step", step, 1);
    #3;
    reset = 1'b1;
    #1;
    chk("areset_step", step, 0);
    chk("areset_busy", busy, 0);
    chk("areset_left", steps_left, 0);
    model_reset();
    period = 0;
    tick   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cycle();
    chk("post_reset_ready", cmd_ready, 1);
    $display("move reset-mid-pulse step=%0d busy=%0d left=%0d", step, busy, steps_left);

    run_move(1, 1'b0, 7, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
